// File: rtl/coin_acc_pkg.sv
// Shared types and defaults for the coin acceptor front end.
package coin_acc_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    DEB_HI   = 2'd2,
    HELD     = 2'd3
  } chan_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W           = 3;
  localparam int DEF_TALLY_W         = 8;

endpackage

// File: rtl/coin_debounce.sv
// One coin slot: 2-flop synchroniser, debounce FSM and counter; emits a 1-cycle fire.
module coin_debounce
  import coin_acc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic fire_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic        s1_q;
  logic        s2_q;
  chan_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= WAIT_LOW;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q holds how many qualifying s2 samples have been seen before this edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire_o  = 1'b0;
    case (state_q)
      WAIT_LOW: begin
        if (s2_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE: begin
        if (s2_q) begin
          state_d = DEB_HI;
          cnt_d   = CNT_ONE;
        end
      end
      DEB_HI: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          fire_o  = 1'b1;
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        // Release must itself be debounced before the slot re-arms.
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      default: begin
        state_d = WAIT_LOW;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: two debounced slots, arbitration and registered credit/reject pulses.
// Optional saturating tallies enabled by defining COIN_ACC_TALLY_EN.
module coin_acceptor
  import coin_acc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int TALLY_W         = DEF_TALLY_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic coin1_raw,
  input  logic coin2_raw,
  input  logic accept_en,
  output logic one_in,
  output logic two_in,
  output logic coin_reject
`ifdef COIN_ACC_TALLY_EN
  ,
  output logic [TALLY_W-1:0] tally_one,
  output logic [TALLY_W-1:0] tally_two
`endif
);

  if (((2 ** CNT_W) <= DEBOUNCE_CYCLES) || (TALLY_W < 1)) begin : g_param_check
    $error("coin_acceptor: CNT_W too small for DEBOUNCE_CYCLES or TALLY_W < 1");
  end

  logic fire1, fire2;
  logic one_d, two_d, rej_d;
  logic one_q, two_q, rej_q;

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_one (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (coin1_raw),
    .fire_o (fire1)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_two (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (coin2_raw),
    .fire_o (fire2)
  );

  // A simultaneous pair or a disabled downstream turns any fire into a reject.
  always_comb begin
    one_d = fire1 & ~fire2 & accept_en;
    two_d = fire2 & ~fire1 & accept_en;
    rej_d = (fire1 | fire2) & ~(one_d | two_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      one_q <= 1'b0;
      two_q <= 1'b0;
      rej_q <= 1'b0;
    end else begin
      one_q <= one_d;
      two_q <= two_d;
      rej_q <= rej_d;
    end
  end

  assign one_in      = one_q;
  assign two_in      = two_q;
  assign coin_reject = rej_q;

`ifdef COIN_ACC_TALLY_EN
  logic [TALLY_W-1:0] tally_one_q, tally_one_d;
  logic [TALLY_W-1:0] tally_two_q, tally_two_d;

  always_comb begin
    tally_one_d = tally_one_q;
    tally_two_d = tally_two_q;
    if (one_d && (tally_one_q != '1)) tally_one_d = tally_one_q + TALLY_W'(1);
    if (two_d && (tally_two_q != '1)) tally_two_d = tally_two_q + TALLY_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tally_one_q <= '0;
      tally_two_q <= '0;
    end else begin
      tally_one_q <= tally_one_d;
      tally_two_q <= tally_two_d;
    end
  end

  assign tally_one = tally_one_q;
  assign tally_two = tally_two_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with a run-length model of the debounce rules.
`timescale 1ns/1ps
module tb_coin_acceptor;

  localparam int DC = 4;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic coin1_raw;
  logic coin2_raw;
  logic accept_en;
  logic one_in, two_in, coin_reject;
`ifdef COIN_ACC_TALLY_EN
  logic [TW-1:0] tally_one, tally_two;
  logic [TW-1:0] exp_q[$];
`endif

  always #50 clk = ~clk;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (3),
    .TALLY_W        (TW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .coin1_raw  (coin1_raw),
    .coin2_raw  (coin2_raw),
    .accept_en  (accept_en),
    .one_in     (one_in),
    .two_in     (two_in),
    .coin_reject(coin_reject)
`ifdef COIN_ACC_TALLY_EN
    ,
    .tally_one  (tally_one),
    .tally_two  (tally_two)
`endif
  );

  int total = 0;
  int bad   = 0;
  int n_one = 0, n_two = 0, n_rej = 0;

  // Model: sample pipeline, run lengths of the synced stream and an armed flag per slot.
  bit m_s1[2], m_s2[2], m_armed[2];
  int m_low[2], m_high[2];
  bit e_one, e_two, e_rej;
  int e_t1, e_t2;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_step();
    bit fire[2];
    bit raw[2];
    raw[0] = coin1_raw;
    raw[1] = coin2_raw;
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_armed[c] = 0; m_low[c] = 0; m_high[c] = 0;
      end
      e_one = 0; e_two = 0; e_rej = 0; e_t1 = 0; e_t2 = 0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        fire[c] = 0;
        if (m_s2[c]) begin
          if (m_high[c] < 1000) m_high[c]++;
          m_low[c] = 0;
        end else begin
          if (m_low[c] < 1000) m_low[c]++;
          m_high[c] = 0;
        end
        if (!m_armed[c] && m_low[c] >= DC) m_armed[c] = 1;
        if (m_armed[c] && m_high[c] == DC) begin
          fire[c] = 1;
          m_armed[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
      end
      e_one = fire[0] && !fire[1] && accept_en;
      e_two = fire[1] && !fire[0] && accept_en;
      e_rej = (fire[0] || fire[1]) && !(e_one || e_two);
      if (e_one && e_t1 < (1 << TW) - 1) e_t1++;
      if (e_two && e_t2 < (1 << TW) - 1) e_t2++;
    end
  endtask

  // One clock: advance the model on the edge, then check every output 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("one_in", int'(one_in), int'(e_one));
    chk("two_in", int'(two_in), int'(e_two));
    chk("coin_reject", int'(coin_reject), int'(e_rej));
    chk("one_two_excl", int'(one_in & two_in), 0);
`ifdef COIN_ACC_TALLY_EN
    chk("tally_one", int'(tally_one), e_t1);
    chk("tally_two", int'(tally_two), e_t2);
`endif
    n_one += int'(one_in);
    n_two += int'(two_in);
    n_rej += int'(coin_reject);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int b1, b2, br, k;
    reset_n = 0; coin1_raw = 0; coin2_raw = 0; accept_en = 1;
    run(3);
    chk("reset_one_in", int'(one_in), 0);
    chk("reset_reject", int'(coin_reject), 0);
    reset_n = 1;
    run(8);

    // 1: single 1-unit coin, latency measured from the first high sample edge.
    b1 = n_one; b2 = n_two; br = n_rej;
    coin1_raw = 1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!one_in && k < 20);
    chk("t1_latency", k, 6);
    run(2);
    coin1_raw = 0;
    run(8);
    chk("t1_one", n_one - b1, 1);
    chk("t1_two", n_two - b2, 0);
    chk("t1_rej", n_rej - br, 0);

    // 2: bouncing 2-unit slot then steady.
    b2 = n_two;
    for (int i = 0; i < 5; i++) begin
      coin2_raw = (i % 2 == 0);
      tick();
    end
    coin2_raw = 1;
    run(10);
    coin2_raw = 0;
    run(8);
    chk("t2_two", n_two - b2, 1);

    // 3: both slots together.
    b1 = n_one; b2 = n_two; br = n_rej;
    coin1_raw = 1; coin2_raw = 1;
    run(10);
    coin1_raw = 0; coin2_raw = 0;
    run(8);
    chk("t3_rej", n_rej - br, 1);
    chk("t3_one", n_one - b1, 0);
    chk("t3_two", n_two - b2, 0);

    // 4: downstream disabled, then enabled.
    b1 = n_one; br = n_rej;
    accept_en = 0; coin1_raw = 1;
    run(8);
    coin1_raw = 0; accept_en = 1;
    run(5);
    chk("t4_rej", n_rej - br, 1);
    chk("t4_one_blocked", n_one - b1, 0);
    coin1_raw = 1;
    run(8);
    coin1_raw = 0;
    run(8);
    chk("t4_one", n_one - b1, 1);

    // 5: coin held through reset, then reset mid-debounce.
    b2 = n_two;
    coin2_raw = 1;
    run(3);
    reset_n = 0;
    run(2);
    reset_n = 1;
    run(10);
    chk("t5_held_reset", n_two - b2, 0);
    coin2_raw = 0;
    run(5);
    coin2_raw = 1;
    run(8);
    coin2_raw = 0;
    run(6);
    chk("t5_reinsert", n_two - b2, 1);
    b2 = n_two;
    coin2_raw = 1;
    run(4);
    reset_n = 0; coin2_raw = 0;
    run(2);
    reset_n = 1;
    run(8);
    chk("t5_abort", n_two - b2, 0);

    // Short glitch and stuck-high slot.
    b1 = n_one;
    coin1_raw = 1;
    run(3);
    coin1_raw = 0;
    run(8);
    chk("short_pulse", n_one - b1, 0);
    coin1_raw = 1;
    run(40);
    chk("stuck_high", n_one - b1, 1);
    coin1_raw = 0;
    run(8);

`ifdef COIN_ACC_TALLY_EN
    // 6: saturating 2-bit tally.
    reset_n = 0;
    run(2);
    reset_n = 1;
    run(8);
    exp_q = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      coin1_raw = 1;
      run(8);
      coin1_raw = 0;
      run(6);
      chk("t6_tally_one", int'(tally_one), int'(exp_q.pop_front()));
      chk("t6_tally_two", int'(tally_two), 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
